// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the bit-serial add/subtract unit.
interface serial_addsub_if #(parameter int WIDTH = 4);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             n;
    logic             z;
    logic             v;
    logic             flag;

    modport master (output start, op, a, b,
                    input  busy, done, sum, cout, n, z, v, flag);
    modport slave  (input  start, op, a, b,
                    output busy, done, sum, cout, n, z, v, flag);
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial signed add/subtract: one full-adder cell, LSB first, WIDTH cycles
// per operation, with registered NZCV-style flags and signed less-than.
module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] IDLE  = CW'(0);
    localparam logic [CW-1:0] RUN   = CW'(1);
    localparam logic [CW-1:0] DONE  = CW'(2);
    localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENUL = CW'(WIDTH - 2);

    logic [CW-1:0]    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sr_q, sr_d;
    logic             carry_q, carry_d, cmsb_q, cmsb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d, n_q, n_d, z_q, z_d, v_q, v_d, flag_q, flag_d;

    logic             s, cnext;
    logic [WIDTH-1:0] res;

    always_comb begin
        s       = a_q[0] ^ b_q[0] ^ carry_q;
        cnext   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        res     = {s, sr_q[WIDTH-1:1]};
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sr_d    = sr_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        n_d     = n_q;
        z_d     = z_q;
        v_d     = v_q;
        flag_d  = flag_q;
        case (state_q)
            RUN: begin
                sr_d    = res;
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = cnext;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == PENUL)
                    cmsb_d = cnext;
                // Last bit: publish every result flag in the same edge.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = res;
                    cout_d  = cnext;
                    n_d     = s;
                    z_d     = (res == '0);
                    v_d     = cmsb_q ^ cnext;
                    flag_d  = s ^ (cmsb_q ^ cnext);
                end
            end
            default: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.a;
                    b_d     = bus.op ? ~bus.b : bus.b;
                    carry_d = bus.op;
                    cnt_d   = '0;
                    sr_d    = '0;
                    cmsb_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sr_q    <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sr_q    <= sr_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            n_q     <= n_d;
            z_q     <= z_d;
            v_q     <= v_d;
            flag_q  <= flag_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.n    = n_q;
    assign bus.z    = z_q;
    assign bus.v    = v_q;
    assign bus.flag = flag_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops
// and compares them on every done pulse.
module tb_serial_addsub;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(W)) bus ();
    serial_addsub #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         n;
        logic         z;
        logic         v;
        logic         flag;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc++;

    function automatic exp_t mk(logic [W-1:0] s, logic c, logic n, logic z, logic v, logic f);
        exp_t e;
        e.sum = s; e.cout = c; e.n = n; e.z = z; e.v = v; e.flag = f;
        return e;
    endfunction

    function automatic exp_t model(logic o, logic [W-1:0] a, logic [W-1:0] b);
        exp_t       e;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb     = o ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, o};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.n    = e.sum[W-1];
        e.z    = (e.sum == '0);
        if (o) e.v = (a[W-1] != b[W-1]) && (e.sum[W-1] != a[W-1]);
        else   e.v = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
        e.flag = o ? ($signed(a) < $signed(b)) : (e.n ^ e.v);
        return e;
    endfunction

    function automatic exp_t got();
        return mk(bus.sum, bus.cout, bus.n, bus.z, bus.v, bus.flag);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        if (bus.done) begin
            tests++;
            if (bus.busy) begin
                fails++;
                $display("FAIL busy_done_overlap busy=%b done=%b required busy=0", bus.busy, bus.done);
            end
            tests++;
            g = got();
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done got sum=%0d required no done", bus.sum);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    fails++;
                    $display("FAIL result got sum=%0d c=%b n=%b z=%b v=%b f=%b required sum=%0d c=%b n=%b z=%b v=%b f=%b",
                             g.sum, g.cout, g.n, g.z, g.v, g.flag, e.sum, e.cout, e.n, e.z, e.v, e.flag);
                end
            end
        end
    end

    // Waits for done, requiring busy high on every cycle before it.
    task automatic wait_done(input int exp_lat, input string tag);
        int lat;
        lat = 0;
        while (!bus.done && lat < 20) begin
            if (!bus.busy) begin
                tests++; fails++;
                $display("FAIL %s_busy got busy=0 required 1 at lat=%0d", tag, lat);
            end
            @(negedge clk);
            lat++;
        end
        tests++;
        if (!bus.done || lat != exp_lat) begin
            fails++;
            $display("FAIL %s_latency got done=%b lat=%0d required done=1 lat=%0d", tag, bus.done, lat, exp_lat);
        end
    endtask

    task automatic do_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.a = a; bus.b = b;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(W, "op");
    endtask

    initial begin
        int prev;
        bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.busy, bus.done, got()} !== '0) begin
            fails++;
            $display("FAIL reset_state got busy=%b done=%b sum=%0d flags=%b%b%b%b%b required all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.n, bus.z, bus.v, bus.flag);
        end
        rst_n = 1'b1;

        // Directed vectors: {sum, cout, n, z, v, flag}
        do_op(1'b0, 4'd3,  4'd4, mk(4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        do_op(1'b0, 4'd7,  4'd1, mk(4'd8,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        do_op(1'b0, 4'hF,  4'd1, mk(4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        do_op(1'b1, 4'd3,  4'd5, mk(4'd14, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        do_op(1'b1, 4'd5,  4'd5, mk(4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        do_op(1'b1, 4'd8,  4'd1, mk(4'd7,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1));

        // Start pulsed mid-RUN must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 4'd3; bus.b = 4'd4;
        exp_q.push_back(mk(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b1; bus.a = 4'd5; bus.b = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(W - 2, "ignore");

        // Back-to-back with start held high.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 4'd2; bus.b = 4'd3;
        exp_q.push_back(mk(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            int lim;
            lim = 0;
            @(negedge clk);
            while (!bus.done && lim < 20) begin @(negedge clk); lim++; end
            tests++;
            if (!bus.done || (i > 0 && cyc - prev != W + 1)) begin
                fails++;
                $display("FAIL b2b_period got done=%b period=%0d required done=1 period=%0d", bus.done, cyc - prev, W + 1);
            end
            prev = cyc;
            if (i == 0) begin
                bus.op = 1'b1; bus.a = 4'd1; bus.b = 4'd2;
                exp_q.push_back(mk(4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
            end else if (i == 1) begin
                bus.op = 1'b0; bus.a = 4'd12; bus.b = 4'd12;
                exp_q.push_back(mk(4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
            end else begin
                bus.start = 1'b0;
            end
        end

        // Reset two cycles into RUN aborts without a done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 4'd3; bus.b = 4'd4;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.busy, bus.done, got()} !== '0) begin
            fails++;
            $display("FAIL midrun_reset got busy=%b done=%b sum=%0d flags=%b%b%b%b%b required all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.n, bus.z, bus.v, bus.flag);
        end
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        do_op(1'b1, 4'd6, 4'd2, mk(4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        // Exhaustive sweep against the arithmetic reference.
        for (int o = 0; o < 2; o++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    do_op(o[0], a[W-1:0], b[W-1:0], model(o[0], a[W-1:0], b[W-1:0]));

        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial signed add/subtract unit with full condition flags. It accepts two WIDTH-bit two's-complement operands through a start/done handshake. It resolves one bit per clock through a single full-adder cell and a carry register. It reports the result as sum, carry, negative, zero and overflow flags, plus the signed less-than flag n^v. It is the sequential, add-direction counterpart of the combinational 4-bit subtract/compare datapath, for area-constrained paths where latency is acceptable.

## Interface
- WIDTH, 4, operand and result width in bits; legal range 2..16.

- clk  in  1  rising-edge clock; the design uses one clock only.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request to begin an operation; sampled only in IDLE or DONE.
- op  in  1  0 = a+b, 1 = a-b; sampled with start.
- a  in  WIDTH  operand A, two's complement; sampled with start.
- b  in  WIDTH  operand B, two's complement; sampled with start.
- busy  out  1  high while an operation is in progress (RUN).
- done  out  1  one-cycle pulse; the result outputs are valid from this cycle on.
- sum  out  WIDTH  result a+b or a-b, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB; for subtract, 1 = no borrow.
- n  out  1  sum[WIDTH-1].
- z  out  1  1 when sum == 0.
- v  out  1  signed overflow, equal to the carry into the MSB XOR the carry out of the MSB.
- flag  out  1  n^v; for op=1 this is 1 exactly when a < b (signed).

## Operation
- States: IDLE, RUN, DONE. The state register and bit counter are sized clog2(WIDTH)+1.
- Start acceptance:
  - When start=1 is sampled in IDLE or DONE, the block loads A_reg=a.
  - It loads B_reg=b when op=0, or B_reg=~b when op=1.
  - It loads carry=op and bit counter=0, then enters RUN.
- RUN, one cycle per bit, LSB first:
  - The full adder computes s = A_reg[0]^B_reg[0]^carry and cnext = majority(A_reg[0], B_reg[0], carry).
  - s shifts into the MSB of the shift/result register; A_reg and B_reg shift right by one.
  - carry <= cnext and the counter increments.
  - When the counter equals WIDTH-2, the block also captures cnext as c_msb_in, the carry into the MSB.
  - After processing bit WIDTH-1, the block enters DONE.
- DONE entry: all result outputs register together.
  - sum = the completed shift register; cout = final cnext.
  - n = sum MSB; z = (sum==0); v = c_msb_in ^ cout; flag = n ^ v.
- DONE lasts exactly one cycle with done=1. It goes to IDLE if start=0, or reloads and goes to RUN if start=1 (back-to-back).
- start is ignored while in RUN. a, b and op may change freely after they are sampled.
- Result outputs hold their values until the next DONE entry; they never show partial results.
- Reset (rst_n=0 at a clock edge):
  - state goes to IDLE; busy=0, done=0.
  - sum, cout, n, z, v and flag all go to 0; internal registers clear.
  - Reset during RUN aborts the operation, and no done pulse is produced for it.
  - Reset has priority over start.

## Timing
- Edge k samples start=1. busy=1 from after edge k until edge k+WIDTH.
- Edge k+WIDTH enters DONE. done=1 and the results are valid during the cycle after edge k+WIDTH.
- Latency from the start edge to done is WIDTH cycles.
- Throughput is one operation per WIDTH+1 cycles when start is held high continuously.
- busy and done are never high together. done never rises without a preceding accepted start.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset, then add: op=0, a=3, b=4 -> done 4 cycles after the start edge; sum=7, cout=0, n=0, z=0, v=0, flag=0.
- Add with overflow: op=0, a=7, b=1 -> sum=8 (1000b), n=1, v=1, flag=0, cout=0. Also op=0, a=-1, b=1 -> sum=0, z=1, cout=1, v=0.
- Subtract and compare:
  - op=1, a=3, b=5 -> sum=14, cout=0, n=1, v=0, flag=1.
  - op=1, a=5, b=5 -> sum=0, z=1, cout=1, flag=0.
  - op=1, a=-8, b=1 -> sum=7, v=1, n=0, flag=1.
- Exhaustive check at WIDTH=4, all 512 combinations of op, a and b:
  - sum, cout and v must match the arithmetic reference.
  - For op=1, flag must equal (signed a < signed b).
- Handshake:
  - Pulse start again mid-RUN with different operands -> it is ignored; the original result is reported and busy stays high throughout.
  - Hold start high -> back-to-back operations, with done every 5 cycles at WIDTH=4.
- Reset mid-operation: assert rst_n=0 two cycles into RUN -> no done, all outputs 0, busy=0. A new start after release completes correctly.
